tetris_input_ctrl: RTL and testbench

Conditions raw player input for the Tetris core. It converts two unsigned joystick ADC samples and a bouncing push-button into clean `move_left`/`move_right`/`move_down` levels and a debounced `rotate` level, which drive the grid/game-logic stage directly. It sits between the ADC interface block and the grid stage, and is the only place where thresholds, hysteresis, debounce and stale-sample handling are applied.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/axis_hyst.sv | 78 +++++++
 rtl/tetris_input_ctrl.sv | 140 ++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and default constants for the Tetris player-input conditioning logic.
package tetris_pkg;

   // Per-axis joystick position as seen by the game logic.
   typedef enum logic [1:0] {
      AX_CENTER = 2'd0,
      AX_NEG    = 2'd1,
      AX_POS    = 2'd2
   } axis_state_t;

   // Default ADC format and thresholds for a 12-bit centred joystick.
   localparam int DEF_ADC_W      = 12;
   localparam int DEF_LOW_TH     = 1024;
   localparam int DEF_HIGH_TH    = 3072;
   localparam int DEF_HYST       = 128;

   // Default timing: 10 ms debounce and 100 ms stale-sample limit at 50 MHz.
   localparam int DEF_DEB_CYCLES = 500_000;
   localparam int DEF_TIMEOUT    = 5_000_000;

   // True when the release points of the two deflection zones do not overlap.
   function automatic bit hyst_window_ok(input int low_th, input int high_th, input int hyst);
      return (low_th + hyst) < (high_th - hyst);
   endfunction

endpackage

// File: rtl/axis_hyst.sv
// One joystick axis: three-state hysteresis FSM with a force-to-centre input.
module axis_hyst
   import tetris_pkg::*;
#(
   parameter int ADC_W   = DEF_ADC_W,
   parameter int LOW_TH  = DEF_LOW_TH,
   parameter int HIGH_TH = DEF_HIGH_TH,
   parameter int HYST    = DEF_HYST
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ADC_W-1:0] sample,
   input  logic             sample_valid,
   input  logic             force_center,
   output logic [1:0]       state
);

   // Refuse to build with overlapping release zones or thresholds that do not fit the sample.
   if (!hyst_window_ok(LOW_TH, HIGH_TH, HYST)) begin : g_bad_hyst
      $error("axis_hyst: LOW_TH + HYST must be below HIGH_TH - HYST");
   end
   if (HIGH_TH >= (1 << ADC_W) || LOW_TH <= 0) begin : g_bad_range
      $error("axis_hyst: thresholds must lie inside the ADC range");
   end

   localparam logic [ADC_W-1:0] LOW_V     = ADC_W'(LOW_TH);
   localparam logic [ADC_W-1:0] HIGH_V    = ADC_W'(HIGH_TH);
   localparam logic [ADC_W-1:0] REL_NEG_V = ADC_W'(LOW_TH + HYST);
   localparam logic [ADC_W-1:0] REL_POS_V = ADC_W'(HIGH_TH - HYST);

   axis_state_t state_q;
   axis_state_t state_d;

   // State register; reset parks the axis at centre.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= AX_CENTER;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a valid sample always takes priority over the stale-sample centring.
   always_comb begin
      state_d = state_q;
      if (sample_valid) begin
         case (state_q)
            AX_CENTER: begin
               if (sample < LOW_V) begin
                  state_d = AX_NEG;
               end else if (sample > HIGH_V) begin
                  state_d = AX_POS;
               end
            end
            AX_NEG: begin
               if (sample > HIGH_V) begin
                  state_d = AX_POS;
               end else if (sample >= REL_NEG_V) begin
                  state_d = AX_CENTER;
               end
            end
            AX_POS: begin
               if (sample < LOW_V) begin
                  state_d = AX_NEG;
               end else if (sample <= REL_POS_V) begin
                  state_d = AX_CENTER;
               end
            end
            default: state_d = AX_CENTER;
         endcase
      end else if (force_center) begin
         state_d = AX_CENTER;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Player input conditioning: joystick axes with hysteresis and stale-sample timeout,
// plus a synchronised, debounced rotate button.
module tetris_input_ctrl
   import tetris_pkg::*;
#(
   parameter int ADC_W      = DEF_ADC_W,
   parameter int LOW_TH     = DEF_LOW_TH,
   parameter int HIGH_TH    = DEF_HIGH_TH,
   parameter int HYST       = DEF_HYST,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [ADC_W-1:0] adc_x,
   input  logic [ADC_W-1:0] adc_y,
   input  logic             adc_valid,
   input  logic             btn_n,
   output logic             move_left,
   output logic             move_right,
   output logic             move_down,
   output logic             rotate
);

   // Counters need at least two states to be meaningful.
   if (DEB_CYCLES < 2 || TIMEOUT < 2) begin : g_bad_timing
      $error("tetris_input_ctrl: DEB_CYCLES and TIMEOUT must be at least 2");
   end

   localparam int DEB_W = $clog2(DEB_CYCLES);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0]  to_cnt_q;
   logic [TO_W-1:0]  to_cnt_d;
   logic             timeout_fire;

   logic             btn_meta_q;
   logic             btn_meta_d;
   logic             btn_sync_q;
   logic             btn_sync_d;
   logic             btn_s;
   logic [DEB_W-1:0] deb_cnt_q;
   logic [DEB_W-1:0] deb_cnt_d;
   logic             rotate_q;
   logic             rotate_d;

   logic [1:0]       x_state;
   logic [1:0]       y_state;

   // Stale-sample counter: fires on the cycle it would reach TIMEOUT, unless a sample arrives.
   always_comb begin
      to_cnt_d     = to_cnt_q;
      timeout_fire = 1'b0;
      if (adc_valid) begin
         to_cnt_d = '0;
      end else begin
         if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
         if (to_cnt_q >= TO_FIRE) begin
            timeout_fire = 1'b1;
         end
      end
   end

   // Button path: two-flop synchroniser, then a counter that must see the new level
   // for DEB_CYCLES consecutive cycles before rotate follows it.
   always_comb begin
      btn_meta_d = btn_n;
      btn_sync_d = btn_meta_q;
      deb_cnt_d  = deb_cnt_q;
      rotate_d   = rotate_q;
      if (btn_s == rotate_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         rotate_d  = btn_s;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
   end

   assign btn_s = ~btn_sync_q;

   // All control registers; synchroniser resets to the released (high) level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q   <= '0;
         btn_meta_q <= 1'b1;
         btn_sync_q <= 1'b1;
         deb_cnt_q  <= '0;
         rotate_q   <= 1'b0;
      end else begin
         to_cnt_q   <= to_cnt_d;
         btn_meta_q <= btn_meta_d;
         btn_sync_q <= btn_sync_d;
         deb_cnt_q  <= deb_cnt_d;
         rotate_q   <= rotate_d;
      end
   end

   axis_hyst #(
      .ADC_W   (ADC_W),
      .LOW_TH  (LOW_TH),
      .HIGH_TH (HIGH_TH),
      .HYST    (HYST)
   ) u_axis_x (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample       (adc_x),
      .sample_valid (adc_valid),
      .force_center (timeout_fire),
      .state        (x_state)
   );

   axis_hyst #(
      .ADC_W   (ADC_W),
      .LOW_TH  (LOW_TH),
      .HIGH_TH (HIGH_TH),
      .HYST    (HYST)
   ) u_axis_y (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample       (adc_y),
      .sample_valid (adc_valid),
      .force_center (timeout_fire),
      .state        (y_state)
   );

   // Y positive deflection is tracked by its FSM but has no game action.
   assign move_left  = (x_state == AX_NEG);
   assign move_right = (x_state == AX_POS);
   assign move_down  = (y_state == AX_NEG);
   assign rotate     = rotate_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl with a behavioural input model.
module tb_tetris_input_ctrl;

   localparam int ADC_W   = 12;
   localparam int LOW_TH  = 1024;
   localparam int HIGH_TH = 3072;
   localparam int HYST    = 128;
   localparam int DEB     = 16;
   localparam int TMO     = 64;
   localparam int SYNC    = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [ADC_W-1:0] adc_x = '0;
   logic [ADC_W-1:0] adc_y = '0;
   logic             adc_valid = 1'b0;
   logic             btn_n = 1'b1;
   logic             move_left;
   logic             move_right;
   logic             move_down;
   logic             rotate;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: axis direction as -1/0/+1, cycles since last sample, rotate level,
   // and a history of raw button levels (1 = pressed) seen at each clock edge.
   int mx, my, idle;
   bit rot_m;
   bit hist[$];

   always #5 clk = ~clk;

   tetris_input_ctrl #(
      .ADC_W      (ADC_W),
      .LOW_TH     (LOW_TH),
      .HIGH_TH    (HIGH_TH),
      .HYST       (HYST),
      .DEB_CYCLES (DEB),
      .TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .adc_x      (adc_x),
      .adc_y      (adc_y),
      .adc_valid  (adc_valid),
      .btn_n      (btn_n),
      .move_left  (move_left),
      .move_right (move_right),
      .move_down  (move_down),
      .rotate     (rotate)
   );

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int next_dir(input int d, input int s);
      int r;
      r = d;
      if (d == 0) begin
         if (s < LOW_TH) r = -1;
         else if (s > HIGH_TH) r = 1;
      end else if (d < 0) begin
         if (s > HIGH_TH) r = 1;
         else if (s >= LOW_TH + HYST) r = 0;
      end else begin
         if (s < LOW_TH) r = -1;
         else if (s <= HIGH_TH - HYST) r = 0;
      end
      return r;
   endfunction

   function automatic int pick_sample();
      int r;
      r = int'($urandom_range(0, 14));
      case (r)
         0: return 0;
         1: return LOW_TH - 1;
         2: return LOW_TH;
         3: return LOW_TH + HYST - 1;
         4: return LOW_TH + HYST;
         5: return 2048;
         6: return HIGH_TH - HYST;
         7: return HIGH_TH - HYST + 1;
         8: return HIGH_TH;
         9: return HIGH_TH + 1;
         10: return 4095;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   task automatic model_reset();
      mx = 0;
      my = 0;
      idle = 0;
      rot_m = 1'b0;
      hist.delete();
      for (int i = 0; i < DEB + SYNC; i++) hist.push_back(1'b0);
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit held;
      if (adc_valid) begin
         mx = next_dir(mx, int'(adc_x));
         my = next_dir(my, int'(adc_y));
      end else if (idle + 1 >= TMO) begin
         mx = 0;
         my = 0;
      end
      idle = adc_valid ? 0 : ((idle < TMO) ? idle + 1 : TMO);
      hist.push_back(!btn_n);
      // rotate follows once DEB consecutive synchronised samples disagree with it
      held = 1'b1;
      for (int i = 0; i < DEB; i++) begin
         if (hist[hist.size() - 1 - SYNC - i] == rot_m) held = 1'b0;
      end
      if (held) rot_m = !rot_m;
      while (hist.size() > DEB + SYNC + 4) void'(hist.pop_front());
   endtask

   task automatic tick(input bit v, input int x, input int y);
      adc_valid = v;
      adc_x = x[ADC_W-1:0];
      adc_y = y[ADC_W-1:0];
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_tick();
      tick(1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({move_left, move_right, move_down, rotate} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %b expected 0000", {move_left, move_right, move_down, rotate});
      end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         idle_tick();
         n_checks++;
         if ({move_left, move_right, move_down, rotate} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got %b expected 0000", {move_left, move_right, move_down, rotate});
         end
      end
   endtask

   task automatic test_x_sweep();
      int xs[5] = '{2048, 1023, 1100, 1152, 1151};
      bit ex[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      bit prev;
      prev = 1'b0;
      for (int i = 0; i < 5; i++) begin
         adc_valid = 1'b1;
         adc_x = xs[i][ADC_W-1:0];
         adc_y = 12'd2048;
         #2;
         n_checks++;
         if (move_left !== prev) begin
            n_fail++;
            $display("[TB] FAIL sweep_early x=%0d: got %b expected %b", xs[i], move_left, prev);
         end
         tick(1'b1, xs[i], 2048);
         n_checks++;
         if (move_left !== ex[i] || (mx == -1) != ex[i]) begin
            n_fail++;
            $display("[TB] FAIL sweep x=%0d: got %b expected %b", xs[i], move_left, ex[i]);
         end
         prev = ex[i];
      end
   endtask

   task automatic test_direct_swing();
      tick(1'b1, 500, 2048);
      n_checks++;
      if ({move_left, move_right} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL swing_left: got %b expected 10", {move_left, move_right});
      end
      tick(1'b1, 4000, 2048);
      n_checks++;
      if ({move_left, move_right} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL swing_right: got %b expected 01", {move_left, move_right});
      end
   endtask

   task automatic test_y_down();
      tick(1'b1, 4000, 200);
      n_checks++;
      if ({move_left, move_right, move_down} !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL y_down: got %b expected 011", {move_left, move_right, move_down});
      end
      tick(1'b1, 2048, 2048);
      n_checks++;
      if ({move_left, move_right, move_down} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL all_centre: got %b expected 000", {move_left, move_right, move_down});
      end
   endtask

   task automatic test_timeout();
      bit early_drop;
      tick(1'b1, 100, 200);
      early_drop = 1'b0;
      for (int i = 1; i < TMO; i++) begin
         idle_tick();
         if (move_left !== 1'b1 || move_down !== 1'b1) early_drop = 1'b1;
      end
      n_checks++;
      if (early_drop) begin
         n_fail++;
         $display("[TB] FAIL timeout_hold: got early drop expected held for %0d idle cycles", TMO - 1);
      end
      idle_tick();
      n_checks++;
      if ({move_left, move_down} !== 2'b00 || mx != 0 || my != 0) begin
         n_fail++;
         $display("[TB] FAIL timeout_drop: got %b expected 00", {move_left, move_down});
      end
      tick(1'b1, 100, 2048);
      for (int i = 1; i < TMO; i++) idle_tick();
      tick(1'b1, 100, 2048);
      n_checks++;
      if (move_left !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL timeout_sample_wins: got %b expected 1", move_left);
      end
      for (int i = 0; i < 10; i++) idle_tick();
      n_checks++;
      if (move_left !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL timeout_restart: got %b expected 1", move_left);
      end
      for (int i = 0; i < TMO; i++) idle_tick();
      n_checks++;
      if (move_left !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL timeout_second: got %b expected 0", move_left);
      end
   endtask

   task automatic test_debounce();
      bit bounce_rose;
      int edges;
      bounce_rose = 1'b0;
      for (int seg = 0; seg < 8; seg++) begin
         btn_n = (seg % 2 == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < 5; i++) begin
            idle_tick();
            if (rotate !== 1'b0 || rot_m) bounce_rose = 1'b1;
         end
      end
      n_checks++;
      if (bounce_rose) begin
         n_fail++;
         $display("[TB] FAIL bounce_reject: got rotate 1 expected 0 during bounce");
      end
      btn_n = 1'b0;
      edges = 0;
      while (rotate !== 1'b1 && edges < 60) begin
         idle_tick();
         edges++;
      end
      n_checks++;
      if (edges != SYNC + DEB || !rot_m) begin
         n_fail++;
         $display("[TB] FAIL debounce_latency: got %0d edges expected %0d", edges, SYNC + DEB);
      end
      btn_n = 1'b1;
      for (int i = 0; i < 10; i++) idle_tick();
      btn_n = 1'b0;
      bounce_rose = 1'b0;
      for (int i = 0; i < 30; i++) begin
         idle_tick();
         if (rotate !== 1'b1) bounce_rose = 1'b1;
      end
      n_checks++;
      if (bounce_rose) begin
         n_fail++;
         $display("[TB] FAIL glitch_reject: got rotate 0 expected 1 after release glitch");
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      tick(1'b1, 4000, 2048);
      btn_n = 1'b1;
      for (int i = 0; i < 5; i++) idle_tick();
      n_checks++;
      if ({move_right, rotate} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL mid_precondition: got %b expected 11", {move_right, rotate});
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({move_left, move_right, move_down, rotate} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_outputs: got %b expected 0000", {move_left, move_right, move_down, rotate});
      end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      btn_n = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < SYNC + DEB + 4; i++) begin
         idle_tick();
         if (move_right !== 1'b0 || rotate !== rot_m) bad = 1'b1;
      end
      n_checks++;
      if (bad || rotate !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_recovery: got right=%b rotate=%b expected right=0 rotate=1", move_right, rotate);
      end
      tick(1'b1, 4000, 2048);
      n_checks++;
      if (move_right !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_fresh_sample: got %b expected 1", move_right);
      end
   endtask

   task automatic test_random();
      int pct;
      bit v;
      for (int blk = 0; blk < 15; blk++) begin
         case (blk % 3)
            0: pct = 90;
            1: pct = 30;
            default: pct = 1;
         endcase
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 29) == 0) btn_n = ~btn_n;
            v = ($urandom_range(0, 99) < pct);
            tick(v, pick_sample(), pick_sample());
            n_checks++;
            if (move_left !== (mx == -1) || move_right !== (mx == 1) || move_down !== (my == -1)) begin
               n_fail++;
               $display("[TB] FAIL random_axes: got l=%b r=%b d=%b expected l=%b r=%b d=%b",
                        move_left, move_right, move_down, mx == -1, mx == 1, my == -1);
            end
            n_checks++;
            if (rotate !== rot_m) begin
               n_fail++;
               $display("[TB] FAIL random_rotate: got %b expected %b", rotate, rot_m);
            end
            n_checks++;
            if ((move_left & move_right) !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL random_exclusive: got both left and right high expected at most one");
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_x_sweep();
      test_direct_swing();
      test_y_down();
      test_timeout();
      test_debounce();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
